// File: rtl/top_pkg.sv
// Shared defaults and the elaboration-time sine table generator for the PWM sine synthesiser.
// Optional N_PORT_EN (used by top) adds the N hold-multiplier port; this package is unaffected by it.
package top_pkg;

  localparam int R_DEF       = 6;
  localparam int SAMPLES_DEF = 36;

  // sin() of the first quadrant in 10-degree steps, scaled by 2^16
  function automatic int sin_quadrant_q16(input int step);
    case (step)
      0:       return 0;
      1:       return 11380;
      2:       return 22415;
      3:       return 32768;
      4:       return 42125;
      5:       return 50203;
      6:       return 56756;
      7:       return 61584;
      8:       return 64540;
      default: return 65536;
    endcase
  endfunction

  // Full-circle sine in 10-degree steps (0..35), built by quadrant symmetry
  function automatic int sin_q16(input int step);
    int d;
    d = step % 36;
    if (d <= 9)       return  sin_quadrant_q16(d);
    else if (d <= 18) return  sin_quadrant_q16(18 - d);
    else if (d <= 27) return -sin_quadrant_q16(d - 18);
    else              return -sin_quadrant_q16(36 - d);
  endfunction

  // round_half_up((2^r-1)*(1+sin(2*pi*k/samples))/2) in fixed point
  function automatic int sine_entry(input int r, input int samples, input int k);
    longint signed amp;
    longint signed num;
    int            step;
    step = (k * 36 + samples / 2) / samples;
    amp  = (longint'(1) <<< r) - 1;
    num  = amp * (longint'(65536) + longint'(sin_q16(step))) + longint'(65536);
    return int'(num / longint'(131072));
  endfunction

endpackage

// File: rtl/pwm_core.sv
// Free-running R-bit PWM counter, duty comparator and registered output with a period-end strobe.
// Not affected by N_PORT_EN.
module pwm_core #(
  parameter int R = 6
) (
  input  logic         clk,
  input  logic         reset,
  input  logic [R-1:0] duty,
  output logic         pwm_out,
  output logic         period_end
);

  logic [R-1:0] cnt;

  assign period_end = (cnt == {R{1'b1}});

  always_ff @(posedge clk) begin
    if (reset) begin
      cnt     <= '0;
      pwm_out <= 1'b0;
    end else begin
      cnt     <= cnt + 1'b1;
      pwm_out <= (cnt < duty);
    end
  end

endmodule

// File: rtl/top.sv
// Sine-modulated PWM: steps through a sine table, holding each sample for 2*Neff PWM periods.
// Define N_PORT_EN to add input N driving Neff; otherwise Neff is the constant N_DEF.
module top
  import top_pkg::*;
#(
  parameter int          R       = R_DEF,
  parameter int          SAMPLES = SAMPLES_DEF,
  parameter logic [11:0] N_DEF   = 12'd1
) (
  input  logic        clk,
  input  logic        reset,
`ifdef N_PORT_EN
  input  logic [11:0] N,
`endif
  output logic        salidaPWM,
  output logic [11:0] n
);

  localparam int IDX_W = (SAMPLES > 1) ? $clog2(SAMPLES) : 1;

  logic [R-1:0]     sine_rom [SAMPLES];
  logic [R-1:0]     duty;
  logic [IDX_W-1:0] idx;
  logic [IDX_W-1:0] idx_next;
  logic [12:0]      hold;
  logic [12:0]      hold_last;
  logic [11:0]      neff;
  logic [11:0]      n_raw;
  logic [11:0]      neff_in;
  logic             period_end;

  for (genvar k = 0; k < SAMPLES; k++) begin : g_rom
    assign sine_rom[k] = R'(sine_entry(R, SAMPLES, k));
  end

`ifdef N_PORT_EN
  assign n_raw = N;
`else
  assign n_raw = N_DEF;
`endif

  // A hold multiplier of zero would never end a sample, so treat it as one
  assign neff_in   = (n_raw == 12'd0) ? 12'd1 : n_raw;
  assign hold_last = {neff, 1'b0} - 13'd1;
  assign idx_next  = (idx == IDX_W'(SAMPLES - 1)) ? '0 : idx + 1'b1;

  // Sample sequencer: Neff is re-latched only at sample boundaries
  always_ff @(posedge clk) begin
    if (reset) begin
      hold <= '0;
      idx  <= '0;
      duty <= sine_rom[0];
      neff <= neff_in;
    end else if (period_end) begin
      if (hold == hold_last) begin
        hold <= '0;
        idx  <= idx_next;
        duty <= sine_rom[idx_next];
        neff <= neff_in;
      end else begin
        hold <= hold + 13'd1;
      end
    end
  end

  assign n = 12'(duty);

  pwm_core #(.R(R)) u_pwm (
    .clk        (clk),
    .reset      (reset),
    .duty       (duty),
    .pwm_out    (salidaPWM),
    .period_end (period_end)
  );

endmodule

// File: tb/tb_top.sv
// Directed bench for the sine PWM top (R=6, SAMPLES=36); N_PORT_EN adds hold-multiplier steps.
// Expected duty values are hand-computed from the rounded sine formula.
module tb_top;

  logic        clk = 1'b0;
  logic        reset = 1'b1;
  logic        salidaPWM;
  logic [11:0] n;
`ifdef N_PORT_EN
  logic [11:0] N = 12'd1;
`endif

  int cyc    = 0;
  int hi     = 0;
  int checks = 0;
  int passes = 0;

  always #5 clk = ~clk;

  top dut (
    .clk       (clk),
    .reset     (reset),
`ifdef N_PORT_EN
    .N         (N),
`endif
    .salidaPWM (salidaPWM),
    .n         (n)
  );

  task automatic step(input int k);
    for (int i = 0; i < k; i++) begin
      @(posedge clk);
      #1;
      cyc = cyc + 1;
      hi  = hi + int'(salidaPWM);
    end
  endtask

  task automatic run_to(input int t);
    if (t > cyc) step(t - cyc);
  endtask

  task automatic check(input string tag, input int obs, input int exp);
    checks = checks + 1;
    assert (obs === exp) passes = passes + 1;
    else $error("FAIL %s: observed %0d required %0d", tag, obs, exp);
  endtask

  task automatic do_reset();
    reset = 1'b1;
    step(1);
    reset = 1'b0;
    cyc = 0;
  endtask

  initial begin
    // Reset state and first two PWM periods at duty 32
    do_reset();
    check("reset_n", int'(n), 32);
    check("reset_out", int'(salidaPWM), 0);
    hi = 0;
    step(1);
    check("first_edge_out", int'(salidaPWM), 1);
    step(63);
    check("period0_high", hi, 32);
    hi = 0;
    step(63);
    check("hold_before_boundary", int'(n), 32);
    step(1);
    check("period1_high", hi, 32);
    check("sample1_n", int'(n), 37);

    // Peak sample: high 63 of 64 clocks, low on the last count
    run_to(9 * 128);
    check("peak_n", int'(n), 63);
    hi = 0;
    step(64);
    check("peak_high", hi, 63);
    check("peak_last_low", int'(salidaPWM), 0);

    // Trough sample: constant low
    run_to(27 * 128);
    check("trough_n", int'(n), 0);
    hi = 0;
    step(128);
    check("trough_high", hi, 0);

    // Index wrap after a full sine period
    run_to(4607);
    check("last_sample_n", int'(n), 26);
    step(1);
    check("wrap_n", int'(n), 32);

    // Reset in the middle of sample 20 of the second period
    run_to(4608 + 20 * 128 + 50);
    check("idx20_n", int'(n), 21);
    do_reset();
    check("midreset_n", int'(n), 32);
    check("midreset_out", int'(salidaPWM), 0);
    hi = 0;
    step(1);
    check("restart_first_out", int'(salidaPWM), 1);
    step(63);
    check("restart_high", hi, 32);
    run_to(127);
    check("restart_hold_n", int'(n), 32);
    step(1);
    check("restart_sample1_n", int'(n), 37);

`ifdef N_PORT_EN
    // N change mid-sample applies from the next sample; N=0 behaves as 1
    N = 12'd1;
    do_reset();
    run_to(60);
    N = 12'd2;
    run_to(127);
    check("n2_before_boundary", int'(n), 32);
    step(1);
    check("n2_sample1", int'(n), 37);
    run_to(300);
    N = 12'd0;
    run_to(383);
    check("n2_sample1_held", int'(n), 37);
    step(1);
    check("n2_sample2", int'(n), 42);
    run_to(511);
    check("n0_sample2_held", int'(n), 42);
    step(1);
    check("n0_sample3", int'(n), 47);
`endif

    $display("%0d/%0d checks passed", passes, checks);
    $finish;
  end

endmodule

// File: doc/top.md
TOP -- requirements
Module: top

Interface
REQ-001 Parameter R, default 6: PWM resolution in bits; PWM period is 2^R clocks.
REQ-002 Parameter SAMPLES, default 36: sine table entries per sine period (10-degree steps).
REQ-003 Parameter N_DEF, default 1: 12-bit hold multiplier used when N_PORT_EN is undefined.
REQ-004 clk  input  1: single system clock; all logic on rising edge.
REQ-005 reset  input  1: synchronous, active-high reset.
REQ-006 N  input  12: hold multiplier; present only when N_PORT_EN is defined.
REQ-007 salidaPWM  output  1: registered sine-modulated PWM output.
REQ-008 n  output  12: current duty word, zero-extended from R bits.

Function
REQ-009 An R-bit PWM counter shall increment every clock and wrap from 2^R-1 to 0.
REQ-010 The registered output shall follow salidaPWM <= (pwm_cnt < duty): one clock of latency from the compare to the pin.
REQ-011 duty = 0 shall give a constant low output, and duty = 2^R-1 shall give high for 2^R-1 of every 2^R clocks.
REQ-012 Each table sample shall be held for 2*Neff PWM periods, i.e. 2^(R+1)*Neff clocks.
REQ-013 Neff = N (or N_DEF), except that a value of 0 shall be treated as 1.
REQ-014 A hold counter shall count completed PWM periods, incrementing when pwm_cnt = 2^R-1.
REQ-015 When the hold counter reaches 2*Neff-1 at pwm_cnt = 2^R-1, the hold counter shall clear, the sample index shall advance, and duty shall load the next table entry on that same edge.
REQ-016 The sample index shall run 0..SAMPLES-1 and wrap from SAMPLES-1 to 0.
REQ-017 One full sine period shall take SAMPLES*2^(R+1)*Neff clocks (4608 clocks for R=6, Neff=1).
REQ-018 table[k] = round_half_up((2^R-1)*(1+sin(2*pi*k/SAMPLES))/2).
REQ-019 For R=6 the table values shall include: k0=32, k9=63, k18=32, k27=0.
REQ-020 A change of N shall take effect only at the next sample boundary; Neff shall be latched at each boundary.
REQ-021 Output n shall equal the duty register, updated on the same edge as duty.

Reset
REQ-022 While reset=1 at a clock edge:
- pwm_cnt, hold counter and index shall clear to 0;
- duty and n shall load table[0] (32 for R=6);
- salidaPWM shall be 0;
- Neff shall latch the current N.
REQ-023 Reset asserted mid-sample shall abandon the sample immediately.
REQ-024 On the first edge after reset releases, salidaPWM shall go 1 for R=6, since 0 < 32.

Configuration
REQ-025 Macro N_PORT_EN.
- Defined: input port N is present and drives Neff.
- Undefined: there is no N port, and Neff is the constant N_DEF.
- All other behaviour is identical in both cases.

Structure
REQ-026 Package top_pkg shall hold R and SAMPLES defaults and a constant function or array that generates the sine table.
REQ-027 One sub-module, pwm_core, shall contain the R-bit counter, the comparator and the output register, and shall expose a period-end strobe.
REQ-028 top shall contain the hold counter, the index, the duty register and the table lookup.

Verification
REQ-029 Reset for 1 clock, R=6, Neff=1 -> n=32; after release, salidaPWM is high for 32 of every 64 clocks over the first 128 clocks.
REQ-030 Neff=1, run 9*128 clocks after reset -> n=63; salidaPWM is high 63 and low 1 per 64-clock period.
REQ-031 Neff=1, run 27*128 clocks -> n=0 and salidaPWM constant 0; at clock 4608 the index wraps and n=32.
REQ-032 N_PORT_EN defined, N switched 1->2 mid-sample -> the current sample completes at 128 clocks, then each later sample lasts 256 clocks.
REQ-033 N=0 -> behaves exactly as N=1 (sample length 128 clocks).
REQ-034 Reset asserted mid-sine at index 20 for one clock -> next edge gives index 0, n=32, salidaPWM 0, then restart per REQ-029.
